rstation_issue: RTL and testbench

- Initiator side of the register-file read/writeback interface.
- Buffers decoded micro-ops in a small FIFO and presents the head entry's operand addresses and PC to the register file.
- Replays the head entry whenever the register file raises abort.
- One cycle after a successful issue, drives the writeback controls (dest_r_wr, dest_r_addr, dest_w_flags) in step with the ALU result.

---
 rtl/rstation_issue_if.sv | 34 +++
 rtl/rstation_issue.sv | 131 +++++++++++++
 tb/tb_rstation_issue.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rstation_issue_if.sv
// Decode / register-file / writeback signal bundle for the reservation-station issue block.
// master = the issue block, slave = decode, register file and writeback agents.
interface rstation_issue_if;
    logic        flush;
    logic        uop_valid;
    logic        uop_ready;
    logic [2:0]  uop_a_addr;
    logic [2:0]  uop_b_addr;
    logic [15:0] uop_pc;
    logic [1:0]  uop_dest;
    logic        uop_wr;
    logic        uop_wflags;
    logic [2:0]  r_a_addr;
    logic [2:0]  r_b_addr;
    logic [15:0] r_pc;
    logic        issue_valid;
    logic        abort;
    logic        dest_r_wr;
    logic [1:0]  dest_r_addr;
    logic        dest_w_flags;
    logic        stall;

    modport master (
        input  flush, uop_valid, uop_a_addr, uop_b_addr, uop_pc, uop_dest, uop_wr, uop_wflags, abort,
        output uop_ready, r_a_addr, r_b_addr, r_pc, issue_valid, dest_r_wr, dest_r_addr,
               dest_w_flags, stall
    );

    modport slave (
        output flush, uop_valid, uop_a_addr, uop_b_addr, uop_pc, uop_dest, uop_wr, uop_wflags, abort,
        input  uop_ready, r_a_addr, r_b_addr, r_pc, issue_valid, dest_r_wr, dest_r_addr,
               dest_w_flags, stall
    );
endinterface

// File: rtl/rstation_issue.sv
// Micro-op FIFO that presents its head to the register file, replays on abort and drives writeback.
// Optional RSTATION_PERF_EN adds perf_issued / perf_aborted counters.
module rstation_issue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef RSTATION_PERF_EN
    output logic [15:0] perf_issued,
    output logic [15:0] perf_aborted,
`endif
    rstation_issue_if.master bus
);
    typedef struct packed {
        logic [2:0]  a;
        logic [2:0]  b;
        logic [15:0] pc;
        logic [1:0]  dest;
        logic        wr;
        logic        wflags;
    } uop_t;

    typedef enum logic [1:0] {IDLE, ISSUE, REPLAY} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

    uop_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    state_t           state_q, state_d;
    uop_t             head;
    logic             live, push, pop, abort_ev, last_pop;

    assign head     = mem[rd_ptr];
    assign live     = (count != '0);
    assign push     = bus.uop_valid & bus.uop_ready & ~bus.flush;
    assign pop      = live & ~bus.abort & ~bus.flush;
    assign abort_ev = live & bus.abort & ~bus.flush;
    assign last_pop = pop & (count == ONE_CNT) & ~push;

    // Readiness comes from the registered count only, so abort never feeds back into decode.
    assign bus.uop_ready   = (count != FULL_CNT);
    assign bus.issue_valid = live;
    assign bus.r_a_addr    = live ? head.a  : 3'b000;
    assign bus.r_b_addr    = live ? head.b  : 3'b000;
    assign bus.r_pc        = live ? head.pc : 16'h0000;
    assign bus.stall       = (state_q == REPLAY);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr].a      <= bus.uop_a_addr;
            mem[wr_ptr].b      <= bus.uop_b_addr;
            mem[wr_ptr].pc     <= bus.uop_pc;
            mem[wr_ptr].dest   <= bus.uop_dest;
            mem[wr_ptr].wr     <= bus.uop_wr;
            mem[wr_ptr].wflags <= bus.uop_wflags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (push) state_d = ISSUE;
                ISSUE:   if (abort_ev) state_d = REPLAY;
                         else if (last_pop) state_d = IDLE;
                REPLAY:  if (pop) state_d = last_pop ? IDLE : ISSUE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Writeback stage lines up with the ALU result one cycle after the pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dest_r_wr    <= 1'b0;
            bus.dest_r_addr  <= 2'b00;
            bus.dest_w_flags <= 1'b0;
        end else if (bus.flush) begin
            bus.dest_r_wr    <= 1'b0;
            bus.dest_r_addr  <= 2'b00;
            bus.dest_w_flags <= 1'b0;
        end else begin
            bus.dest_r_wr    <= pop & head.wr;
            bus.dest_w_flags <= pop & head.wflags;
            if (pop) bus.dest_r_addr <= head.dest;
        end
    end

`ifdef RSTATION_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued  <= 16'h0000;
            perf_aborted <= 16'h0000;
        end else begin
            if (pop)      perf_issued  <= perf_issued + 16'h0001;
            if (abort_ev) perf_aborted <= perf_aborted + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_rstation_issue.sv
// Directed table, corner sequences and randomized traffic checked against a queue-based model.
module tb_rstation_issue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    rstation_issue_if bus();
`ifdef RSTATION_PERF_EN
    logic [15:0] perf_issued, perf_aborted;
`endif

    rstation_issue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef RSTATION_PERF_EN
        .perf_issued(perf_issued),
        .perf_aborted(perf_aborted),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  a;
        logic [2:0]  b;
        logic [15:0] pc;
        logic [1:0]  dest;
        logic        wr;
        logic        wf;
    } uop_t;

    typedef struct {
        logic        v;
        uop_t        u;
        logic        ab;
        logic        e_iv;
        logic [2:0]  e_ra;
        logic [2:0]  e_rb;
        logic [15:0] e_pc;
        logic        e_dwr;
        logic [1:0]  e_da;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    // Reference model: the FIFO is a queue, writeback is whatever the last cycle popped.
    uop_t        q[$];
    logic [15:0] issued_log[$];
    logic        m_dwr, m_dwf, m_stall;
    logic [1:0]  m_daddr;
    logic [15:0] m_iss, m_abt;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tbl[11];

    function automatic uop_t mk(logic [2:0] a, logic [2:0] b, logic [15:0] pc,
                                logic [1:0] dest, logic wr, logic wf);
        uop_t u;
        u.a = a; u.b = b; u.pc = pc; u.dest = dest; u.wr = wr; u.wf = wf;
        return u;
    endfunction

    function automatic vec_t row(logic v, uop_t u, logic ab, logic iv, logic [2:0] ra,
                                 logic [2:0] rb, logic [15:0] pc, logic dwr, logic [1:0] da,
                                 logic rdy, logic st);
        vec_t r;
        r.v = v; r.u = u; r.ab = ab; r.e_iv = iv; r.e_ra = ra; r.e_rb = rb; r.e_pc = pc;
        r.e_dwr = dwr; r.e_da = da; r.e_rdy = rdy; r.e_stall = st;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic v, uop_t u, logic ab, logic fl);
        bus.uop_valid  = v;
        bus.uop_a_addr = u.a;
        bus.uop_b_addr = u.b;
        bus.uop_pc     = u.pc;
        bus.uop_dest   = u.dest;
        bus.uop_wr     = u.wr;
        bus.uop_wflags = u.wf;
        bus.abort      = ab;
        bus.flush      = fl;
    endtask

    task automatic model_reset();
        q.delete();
        m_dwr = 0; m_dwf = 0; m_stall = 0; m_daddr = 0; m_iss = 0; m_abt = 0;
    endtask

    task automatic model_edge(logic v, uop_t u, logic ab, logic fl);
        int n = q.size();
        if (fl) begin
            q.delete();
            m_dwr = 0; m_dwf = 0; m_daddr = 0; m_stall = 0;
        end else begin
            bit can_push = v && (n < DEPTH);
            if (n > 0 && !ab) begin
                uop_t h = q.pop_front();
                m_dwr = h.wr; m_dwf = h.wf; m_daddr = h.dest; m_stall = 0;
                m_iss++;
                issued_log.push_back(h.pc);
            end else begin
                m_dwr = 0; m_dwf = 0;
                if (n > 0) begin
                    m_stall = 1;
                    m_abt++;
                end
            end
            if (can_push) q.push_back(u);
        end
    endtask

    task automatic check_model();
        uop_t h = mk(0, 0, 0, 0, 0, 0);
        if (q.size() > 0) h = q[0];
        chk("issue_valid", bus.issue_valid, q.size() != 0);
        chk("r_a_addr", bus.r_a_addr, h.a);
        chk("r_b_addr", bus.r_b_addr, h.b);
        chk("r_pc", bus.r_pc, h.pc);
        chk("uop_ready", bus.uop_ready, q.size() < DEPTH);
        chk("stall", bus.stall, m_stall);
        chk("dest_r_wr", bus.dest_r_wr, m_dwr);
        chk("dest_r_addr", bus.dest_r_addr, m_daddr);
        chk("dest_w_flags", bus.dest_w_flags, m_dwf);
`ifdef RSTATION_PERF_EN
        chk("perf_issued", perf_issued, m_iss);
        chk("perf_aborted", perf_aborted, m_abt);
`endif
    endtask

    uop_t cur_u;
    logic cur_v, cur_ab, cur_fl;

    task automatic cyc_begin(logic v, uop_t u, logic ab, logic fl);
        @(negedge clk);
        cur_v = v; cur_u = u; cur_ab = ab; cur_fl = fl;
        drive(v, u, ab, fl);
        #1 check_model();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_edge(cur_v, cur_u, cur_ab, cur_fl);
    endtask

    task automatic step(logic v, uop_t u, logic ab, logic fl);
        cyc_begin(v, u, ab, fl);
        cyc_end();
    endtask

    task automatic chk_log(string name, logic [15:0] base, int n);
        chk({name, "_count"}, issued_log.size(), n);
        for (int i = 0; i < n && i < issued_log.size(); i++)
            chk({name, "_pc"}, issued_log[i], base + 16'(i));
        issued_log.delete();
    endtask

    initial begin
        uop_t z  = mk(0, 0, 0, 0, 0, 0);
        uop_t u1 = mk(3'd1, 3'd2, 16'h0100, 2'd1, 1'b1, 1'b0);
        uop_t u2 = mk(3'd2, 3'd3, 16'h0200, 2'd2, 1'b1, 1'b0);

        tbl[0]  = row(1, u1, 0, 0, 0, 0, 16'h0000, 0, 2'd0, 1, 0);
        tbl[1]  = row(0, z,  0, 1, 1, 2, 16'h0100, 0, 2'd0, 1, 0);
        tbl[2]  = row(0, z,  0, 0, 0, 0, 16'h0000, 1, 2'd1, 1, 0);
        tbl[3]  = row(0, z,  0, 0, 0, 0, 16'h0000, 0, 2'd1, 1, 0);
        tbl[4]  = row(1, u2, 0, 0, 0, 0, 16'h0000, 0, 2'd1, 1, 0);
        tbl[5]  = row(0, z,  1, 1, 2, 3, 16'h0200, 0, 2'd1, 1, 0);
        tbl[6]  = row(0, z,  1, 1, 2, 3, 16'h0200, 0, 2'd1, 1, 1);
        tbl[7]  = row(0, z,  1, 1, 2, 3, 16'h0200, 0, 2'd1, 1, 1);
        tbl[8]  = row(0, z,  0, 1, 2, 3, 16'h0200, 0, 2'd1, 1, 1);
        tbl[9]  = row(0, z,  0, 0, 0, 0, 16'h0000, 1, 2'd2, 1, 0);
        tbl[10] = row(0, z,  0, 0, 0, 0, 16'h0000, 0, 2'd2, 1, 0);

        drive(0, z, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_issue_valid", bus.issue_valid, 0);
        chk("rst_uop_ready", bus.uop_ready, 1);
        chk("rst_r_pc", bus.r_pc, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_dest_r_wr", bus.dest_r_wr, 0);
        rst_n = 1'b1;

        // Directed single issue and 3-deep abort replay.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].u, tbl[i].ab, 1'b0);
            #1;
            chk($sformatf("tbl%0d_iv", i), bus.issue_valid, tbl[i].e_iv);
            chk($sformatf("tbl%0d_ra", i), bus.r_a_addr, tbl[i].e_ra);
            chk($sformatf("tbl%0d_rb", i), bus.r_b_addr, tbl[i].e_rb);
            chk($sformatf("tbl%0d_pc", i), bus.r_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_dwr", i), bus.dest_r_wr, tbl[i].e_dwr);
            chk($sformatf("tbl%0d_da", i), bus.dest_r_addr, tbl[i].e_da);
            chk($sformatf("tbl%0d_rdy", i), bus.uop_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_stall", i), bus.stall, tbl[i].e_stall);
            @(posedge clk);
            model_edge(tbl[i].v, tbl[i].u, tbl[i].ab, 1'b0);
        end
`ifdef RSTATION_PERF_EN
        @(negedge clk);
        chk("perf_aborted_tbl", perf_aborted, 3);
        chk("perf_issued_tbl", perf_issued, 2);
`endif
        issued_log.delete();

        // Fill to DEPTH behind an aborted head, refuse the fifth, then drain in order.
        step(1, mk(1, 1, 16'h0010, 0, 1, 0), 0, 0);
        for (int i = 1; i < 4; i++) step(1, mk(1, 1, 16'h0010 + 16'(i), 2'(i), 1, 0), 1, 0);
        cyc_begin(1, mk(1, 1, 16'h0014, 0, 1, 1), 1, 0);
        chk("full_ready", bus.uop_ready, 0);
        cyc_end();
        cyc_begin(1, mk(1, 1, 16'h0014, 0, 1, 1), 0, 0);
        chk("full_pop_ready", bus.uop_ready, 0);
        cyc_end();
        cyc_begin(1, mk(1, 1, 16'h0014, 0, 1, 1), 0, 0);
        chk("after_pop_ready", bus.uop_ready, 1);
        cyc_end();
        repeat (5) step(0, z, 0, 0);
        chk_log("fill", 16'h0010, 5);

        // Continuous push while issuing: pointers wrap, order preserved.
        for (int i = 0; i < 6; i++) step(1, mk(3'(i), 3'(i + 1), 16'h0020 + 16'(i), 2'(i), 1, 1), 0, 0);
        repeat (3) step(0, z, 0, 0);
        chk_log("wrap", 16'h0020, 6);

        // Flush in the middle of a replay with three entries queued.
        step(1, mk(1, 2, 16'h0030, 1, 1, 0), 0, 0);
        step(1, mk(1, 2, 16'h0031, 1, 1, 0), 1, 0);
        step(1, mk(1, 2, 16'h0032, 1, 1, 0), 1, 0);
        step(1, mk(1, 2, 16'h0033, 1, 1, 0), 1, 1);
        cyc_begin(0, z, 0, 0);
        chk("flush_iv", bus.issue_valid, 0);
        chk("flush_dwr", bus.dest_r_wr, 0);
        chk("flush_stall", bus.stall, 0);
        chk("flush_ready", bus.uop_ready, 1);
        cyc_end();

        // Asynchronous reset during replay with two entries queued.
        step(1, mk(4, 5, 16'h0040, 3, 1, 1), 0, 0);
        step(1, mk(4, 5, 16'h0041, 3, 1, 1), 1, 0);
        cyc_begin(0, z, 1, 0);
        chk("pre_rst_stall", bus.stall, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_iv", bus.issue_valid, 0);
        chk("mid_rst_ra", bus.r_a_addr, 0);
        chk("mid_rst_pc", bus.r_pc, 0);
        chk("mid_rst_stall", bus.stall, 0);
        chk("mid_rst_dwr", bus.dest_r_wr, 0);
        chk("mid_rst_da", bus.dest_r_addr, 0);
        chk("mid_rst_ready", bus.uop_ready, 1);
        model_reset();
        drive(0, z, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issued_log.delete();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            uop_t r = mk(3'($urandom), 3'($urandom), 16'($urandom), 2'($urandom),
                         1'($urandom), 1'($urandom));
            logic v  = ($urandom_range(0, 99) < 60);
            logic ab = (q.size() > 0) && ($urandom_range(0, 99) < 30);
            logic fl = ($urandom_range(0, 99) < 3);
            step(v, r, ab, fl);
        end
        step(0, z, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
